// File: rtl/product_collector.sv
// product_collector: reassembles byte-serial products (low byte, then high byte) into a small FIFO
// with a valid/ready output. Optional running-sum accumulator of popped products via PROD_ACC_EN.
module product_collector #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int ACC_W  = 24
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_W-1:0]       data_in,
  input  logic                    lsb_out,
  input  logic                    msb_out,
  output logic [2*DATA_W-1:0]     prod_data,
  output logic                    prod_valid,
  input  logic                    prod_ready,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic                    ovf,
  output logic                    seq_err
`ifdef PROD_ACC_EN
  ,
  input  logic                    acc_clr,
  output logic [ACC_W-1:0]        acc_out
`endif
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int PROD_W = 2 * DATA_W;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || ACC_W < 1) begin : g_param_check
    $error("product_collector: DEPTH must be a power of two >= 2 and ACC_W >= 1");
  end

  typedef enum logic {
    WAIT_LSB = 1'b0,
    WAIT_MSB = 1'b1
  } state_e;

  state_e              state_q;
  logic [DATA_W-1:0]   low_q;
  logic                seq_err_q;
  logic [PROD_W-1:0]   mem_q [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q;
  logic [PTR_W-1:0]    rd_ptr_q;
  logic [CNT_W-1:0]    count_q;
  logic [CNT_W-1:0]    count_d;
  logic                ovf_q;

  logic                push_s;
  logic                pop_s;
  logic                full_s;
  logic                wr_s;
  logic                drop_s;

  always_comb begin
    push_s = (state_q == WAIT_MSB) && msb_out && !lsb_out;
    pop_s  = (count_q != {CNT_W{1'b0}}) && prod_ready;
    full_s = (count_q == CNT_W'(DEPTH));
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    wr_s   = push_s && (!full_s || pop_s);
    drop_s = push_s && full_s && !pop_s;
    case ({wr_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= WAIT_LSB;
      low_q     <= {DATA_W{1'b0}};
      seq_err_q <= 1'b0;
    end else begin
      case (state_q)
        WAIT_LSB: begin
          if (lsb_out && msb_out) begin
            seq_err_q <= 1'b1;
          end else if (lsb_out) begin
            low_q   <= data_in;
            state_q <= WAIT_MSB;
          end else if (msb_out) begin
            seq_err_q <= 1'b1;
          end
        end
        WAIT_MSB: begin
          if (lsb_out && msb_out) begin
            seq_err_q <= 1'b1;
          end else if (msb_out) begin
            state_q <= WAIT_LSB;
          end else if (lsb_out) begin
            low_q     <= data_in;
            seq_err_q <= 1'b1;
          end
        end
        default: state_q <= WAIT_LSB;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {PROD_W{1'b0}};
      end
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
      ovf_q    <= 1'b0;
    end else begin
      if (wr_s) begin
        mem_q[wr_ptr_q] <= {data_in, low_q};
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      if (drop_s) begin
        ovf_q <= 1'b1;
      end
      count_q <= count_d;
    end
  end

  always_comb begin
    prod_valid = (count_q != {CNT_W{1'b0}});
    if (prod_valid) begin
      prod_data = mem_q[rd_ptr_q];
    end else begin
      prod_data = {PROD_W{1'b0}};
    end
    fifo_count = count_q;
    ovf        = ovf_q;
    seq_err    = seq_err_q;
  end

`ifdef PROD_ACC_EN
  logic [ACC_W-1:0] acc_q;

  // Clear combined with a pop restarts the sum at the popped value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= {ACC_W{1'b0}};
    end else if (pop_s && acc_clr) begin
      acc_q <= ACC_W'(prod_data);
    end else if (pop_s) begin
      acc_q <= acc_q + ACC_W'(prod_data);
    end else if (acc_clr) begin
      acc_q <= {ACC_W{1'b0}};
    end
  end

  assign acc_out = acc_q;
`endif

endmodule
